ch3_wave_sequencer: RTL and testbench

Controller for sound channel 3, the wave channel. It owns the 16-byte wave RAM and arbitrates access to it between the CPU and the playback datapath. It decodes the NR30–NR34 register writes and sequences the channel: trigger, frequency timer, 32-step sample position, length counter and output level. It sits between the CPU register bus and the sound mixer, and uses the shared 256 Hz length tick and frequency tick from the frame sequencer.

---
 rtl/ch3_wave_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ch3_wave_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ch3_wave_sequencer.sv
// Sound channel 3 (wave channel) controller.
// Owns the 16-byte wave RAM and shares it between the CPU and the playback
// datapath. Decodes NR30..NR34 and sequences trigger, frequency timer,
// 32-step sample position, length counter and output level scaling.
//
// Register bus: reg_wr is a single-clk write strobe qualified by reg_sel.
// There is no ready/backpressure; every strobe is accepted on its edge.
// reg_sel values 5..7 are ignored.
module ch3_wave_sequencer #(
    parameter int LEN_BITS  = 9,
    parameter int FREQ_BITS = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reg_wr,
    input  logic [2:0] reg_sel,
    input  logic [7:0] reg_wdata,
    input  logic       wave_wr,
    input  logic       wave_rd,
    input  logic [3:0] wave_addr,
    input  logic [7:0] wave_wdata,
    output logic [7:0] wave_rdata,
    input  logic       len_tick,
    input  logic       freq_tick,
    output logic       ch3_active,
    output logic [3:0] sample_out,
    output logic       sample_strobe
);

    // The timer holds 2048 - freq, which needs one bit more than freq.
    localparam int TMR_BITS = FREQ_BITS + 1;
    localparam logic [TMR_BITS-1:0] TMR_PERIOD = TMR_BITS'(1) << FREQ_BITS;
    localparam logic [LEN_BITS-1:0] LEN_FULL   = LEN_BITS'(256);

    // Register fields
    logic                 dac_en;
    logic [1:0]           level;
    logic [FREQ_BITS-1:0] freq;
    logic                 len_en;

    // Channel sequencing state
    logic [TMR_BITS-1:0]  freq_timer;
    logic [LEN_BITS-1:0]  len_counter;
    logic [4:0]           position;
    logic [7:0]           wave_ram [16];

    // Sample pipeline: fetch -> sample_buf -> out_reg/strobe
    logic                 fetch_pending;
    logic [3:0]           sample_buf;
    logic                 fetch_done;
    logic [3:0]           out_reg;

    // Decoded strobes
    logic wr_nr30, wr_nr31, wr_nr32, wr_nr33, wr_nr34;
    logic trigger;
    logic tick_run;
    logic advance;
    logic len_dec;
    logic len_expire;

    logic [FREQ_BITS-1:0] trig_freq;
    logic [TMR_BITS-1:0]  reload_val;
    logic [TMR_BITS-1:0]  trig_reload;
    logic [7:0]           fetch_byte;
    logic [3:0]           fetch_nibble;
    logic [3:0]           scaled;

    assign wr_nr30 = reg_wr && (reg_sel == 3'd0);
    assign wr_nr31 = reg_wr && (reg_sel == 3'd1);
    assign wr_nr32 = reg_wr && (reg_sel == 3'd2);
    assign wr_nr33 = reg_wr && (reg_sel == 3'd3);
    assign wr_nr34 = reg_wr && (reg_sel == 3'd4);
    assign trigger = wr_nr34 && reg_wdata[7];

    // A trigger reloads with the frequency including the high bits it writes.
    assign trig_freq   = {reg_wdata[2:0], freq[7:0]};
    assign reload_val  = TMR_PERIOD - {1'b0, freq};
    assign trig_reload = TMR_PERIOD - {1'b0, trig_freq};

    // A trigger in the same clk swallows the frequency tick.
    assign tick_run = freq_tick && ch3_active && !trigger;
    assign advance  = tick_run && (freq_timer == TMR_BITS'(1));

    // A trigger or NR31 write in the same clk swallows the length tick.
    assign len_dec    = len_tick && len_en && (len_counter != '0) && !trigger && !wr_nr31;
    assign len_expire = len_dec && (len_counter == LEN_BITS'(1));

    assign fetch_byte   = wave_ram[position[4:1]];
    assign fetch_nibble = position[0] ? fetch_byte[3:0] : fetch_byte[7:4];

    // Output level shift
    always_comb begin
        scaled = 4'd0;
        case (level)
            2'd0: scaled = 4'd0;
            2'd1: scaled = sample_buf;
            2'd2: scaled = {1'b0, sample_buf[3:1]};
            2'd3: scaled = {2'b00, sample_buf[3:2]};
            default: scaled = 4'd0;
        endcase
    end

    // Silence the mixer input whenever the channel is not playing.
    assign sample_out = ch3_active ? out_reg : 4'd0;

    // Register file: stored fields of NR30, NR32, NR33, NR34
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_en <= 1'b0;
            level  <= 2'd0;
            freq   <= '0;
            len_en <= 1'b0;
        end else begin
            if (wr_nr30) dac_en <= reg_wdata[7];
            if (wr_nr32) level <= reg_wdata[6:5];
            if (wr_nr33) freq[7:0] <= reg_wdata;
            if (wr_nr34) begin
                freq[FREQ_BITS-1:8] <= reg_wdata[2:0];
                len_en              <= reg_wdata[6];
            end
        end
    end

    // Channel enable, frequency timer and sample position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch3_active <= 1'b0;
            freq_timer <= TMR_PERIOD;
            position   <= 5'd0;
        end else begin
            if (trigger) begin
                ch3_active <= dac_en;
                freq_timer <= trig_reload;
                position   <= 5'd0;
            end else begin
                if ((wr_nr30 && !reg_wdata[7]) || len_expire)
                    ch3_active <= 1'b0;
                if (advance) begin
                    freq_timer <= reload_val;
                    position   <= position + 5'd1;
                end else if (tick_run) begin
                    freq_timer <= freq_timer - TMR_BITS'(1);
                end
            end
        end
    end

    // Length counter: NR31 load, trigger reload from zero, tick decrement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_counter <= '0;
        end else if (wr_nr31) begin
            len_counter <= LEN_FULL - LEN_BITS'(reg_wdata);
        end else if (trigger) begin
            if (len_counter == '0) len_counter <= LEN_FULL;
        end else if (len_dec) begin
            len_counter <= len_counter - LEN_BITS'(1);
        end
    end

    // Wave RAM with CPU port; the player owns it while the channel is active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) wave_ram[i] <= 8'h00;
            wave_rdata <= 8'h00;
        end else begin
            if (wave_wr && !ch3_active) wave_ram[wave_addr] <= wave_wdata;
            if (wave_rd) wave_rdata <= ch3_active ? 8'hFF : wave_ram[wave_addr];
        end
    end

    // Sample pipeline: fetch on the clk after a position change, publish one clk later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pending <= 1'b0;
            sample_buf    <= 4'd0;
            fetch_done    <= 1'b0;
            out_reg       <= 4'd0;
            sample_strobe <= 1'b0;
        end else begin
            fetch_pending <= trigger ? dac_en : advance;
            fetch_done    <= fetch_pending;
            if (fetch_pending) sample_buf <= fetch_nibble;
            out_reg       <= scaled;
            sample_strobe <= fetch_done;
        end
    end

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Directed bench for ch3_wave_sequencer.
module tb_ch3_wave_sequencer;

    logic       clk;
    logic       reset_n;
    logic       reg_wr;
    logic [2:0] reg_sel;
    logic [7:0] reg_wdata;
    logic       wave_wr;
    logic       wave_rd;
    logic [3:0] wave_addr;
    logic [7:0] wave_wdata;
    logic [7:0] wave_rdata;
    logic       len_tick;
    logic       freq_tick;
    logic       ch3_active;
    logic [3:0] sample_out;
    logic       sample_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pat [8];
    logic [7:0] rd;
    int         strobe_cnt;

    ch3_wave_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .reg_wr        (reg_wr),
        .reg_sel       (reg_sel),
        .reg_wdata     (reg_wdata),
        .wave_wr       (wave_wr),
        .wave_rd       (wave_rd),
        .wave_addr     (wave_addr),
        .wave_wdata    (wave_wdata),
        .wave_rdata    (wave_rdata),
        .len_tick      (len_tick),
        .freq_tick     (freq_tick),
        .ch3_active    (ch3_active),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clk; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] sel, input logic [7:0] data);
        reg_wr    = 1'b1;
        reg_sel   = sel;
        reg_wdata = data;
        step();
        reg_wr    = 1'b0;
    endtask

    task automatic ram_write(input logic [3:0] addr, input logic [7:0] data);
        wave_wr    = 1'b1;
        wave_addr  = addr;
        wave_wdata = data;
        step();
        wave_wr    = 1'b0;
    endtask

    task automatic ram_read(input logic [3:0] addr, output logic [7:0] data);
        wave_rd   = 1'b1;
        wave_addr = addr;
        step();
        wave_rd   = 1'b0;
        data      = wave_rdata;
    endtask

    task automatic len_pulse();
        len_tick = 1'b1;
        step();
        len_tick = 1'b0;
    endtask

    // Trigger at freq=2047 and tick every clk for n published samples.
    // Nibbles run 0..F twice over the 32 positions, so sample k is k%16.
    task automatic play(input int n);
        reg_write(3'd4, 8'h87);
        check_val("play_trig_active", ch3_active, 1);
        check_val("play_trig_pos", dut.position, 0);
        freq_tick = 1'b1;
        step();
        for (int k = 0; k < n; k++) begin
            step();
            check_val("play_sample", sample_out, k % 16);
            check_val("play_strobe", sample_strobe, 1);
        end
        freq_tick = 1'b0;
        repeat (3) step();
        check_val("play_settle_sample", sample_out, (n + 1) % 16);
        check_val("play_settle_strobe", sample_strobe, 0);
        check_val("play_settle_pos", dut.position, (n + 1) % 32);
    endtask

    initial begin
        pat = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        reset_n    = 1'b0;
        reg_wr     = 1'b0;
        reg_sel    = 3'd0;
        reg_wdata  = 8'h00;
        wave_wr    = 1'b0;
        wave_rd    = 1'b0;
        wave_addr  = 4'd0;
        wave_wdata = 8'h00;
        len_tick   = 1'b0;
        freq_tick  = 1'b0;
        repeat (3) step();

        // Reset state
        check_val("rst_active", ch3_active, 0);
        check_val("rst_sample", sample_out, 0);
        check_val("rst_strobe", sample_strobe, 0);
        check_val("rst_rdata", wave_rdata, 0);
        check_val("rst_timer", dut.freq_timer, 2048);
        check_val("rst_len", dut.len_counter, 0);
        reset_n = 1'b1;
        step();

        // Load wave RAM and read back while idle
        for (int i = 0; i < 16; i++) ram_write(4'(i), pat[i % 8]);
        ram_read(4'd3, rd);
        check_val("idle_read3", rd, 8'h67);
        ram_read(4'd14, rd);
        check_val("idle_read14", rd, 8'hCD);

        // Playback through the position wrap
        reg_write(3'd0, 8'h80);
        reg_write(3'd2, 8'h20);
        reg_write(3'd3, 8'hFF);
        play(40);

        // Level scaling on nibble 0xE
        play(13);
        check_val("lvl1_sample", sample_out, 4'hE);
        reg_write(3'd2, 8'h40);
        step();
        check_val("lvl2_sample", sample_out, 7);
        check_val("lvl2_strobe", sample_strobe, 0);
        reg_write(3'd2, 8'h60);
        step();
        check_val("lvl3_sample", sample_out, 3);
        reg_write(3'd2, 8'h00);
        step();
        check_val("lvl0_sample", sample_out, 0);
        check_val("lvl0_active", ch3_active, 1);

        // Length counter expiry
        reg_write(3'd2, 8'h20);
        reg_write(3'd1, 8'hFC);
        check_val("len_load", dut.len_counter, 4);
        reg_write(3'd4, 8'hC7);
        check_val("len_trig_keep", dut.len_counter, 4);
        freq_tick = 1'b1;
        repeat (3) step();
        freq_tick = 1'b0;
        repeat (3) step();
        check_val("len_pre_sample", sample_out, 3);
        repeat (3) len_pulse();
        check_val("len_3_cnt", dut.len_counter, 1);
        check_val("len_3_active", ch3_active, 1);
        len_pulse();
        check_val("len_4_active", ch3_active, 0);
        check_val("len_4_sample", sample_out, 0);
        check_val("len_4_cnt", dut.len_counter, 0);
        len_pulse();
        check_val("len_5_cnt", dut.len_counter, 0);

        // RAM arbitration while playing; trigger from zero length loads 256
        reg_write(3'd4, 8'h87);
        check_val("arb_active", ch3_active, 1);
        check_val("arb_len256", dut.len_counter, 256);
        ram_write(4'd3, 8'h55);
        ram_read(4'd3, rd);
        check_val("arb_read_ff", rd, 8'hFF);
        reg_write(3'd0, 8'h00);
        check_val("dacoff_active", ch3_active, 0);
        ram_read(4'd3, rd);
        check_val("arb_read_orig", rd, 8'h67);

        // Trigger with DAC off stays silent
        reg_write(3'd4, 8'h87);
        check_val("trig_dacoff_active", ch3_active, 0);

        // Trigger and freq_tick in the same clk
        reg_write(3'd0, 8'h80);
        reg_write(3'd4, 8'h87);
        freq_tick = 1'b1;
        repeat (3) step();
        check_val("tick_pos3", dut.position, 3);
        reg_write(3'd3, 8'h00);
        check_val("tick_pos4", dut.position, 4);
        check_val("tick_timer_oldfreq", dut.freq_timer, 1);
        reg_write(3'd4, 8'h84);
        check_val("trigtick_pos", dut.position, 0);
        check_val("trigtick_timer", dut.freq_timer, 1024);
        step();
        check_val("trigtick_dec", dut.freq_timer, 1023);
        check_val("trigtick_pos_hold", dut.position, 0);
        freq_tick = 1'b0;

        // Reset mid-playback
        reg_write(3'd3, 8'hFF);
        reg_write(3'd4, 8'h87);
        freq_tick = 1'b1;
        repeat (5) step();
        ram_read(4'd0, rd);
        check_val("pre_rst_rdata", rd, 8'hFF);
        check_val("pre_rst_active", ch3_active, 1);
        reset_n = 1'b0;
        #1;
        check_val("arst_active", ch3_active, 0);
        check_val("arst_sample", sample_out, 0);
        check_val("arst_strobe", sample_strobe, 0);
        check_val("arst_rdata", wave_rdata, 0);
        #3;
        reset_n = 1'b1;
        strobe_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sample_strobe) strobe_cnt++;
        end
        check_val("post_rst_strobes", strobe_cnt, 0);
        check_val("post_rst_active", ch3_active, 0);
        freq_tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
